// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Brief    : Data-memory request/ready handshake between the pipeline
//            sequencing controller (master) and the data memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
  logic dmem_req;
  logic dmem_ready;

  modport master (
    output dmem_req,
    input  dmem_ready
  );

  modport slave (
    input  dmem_req,
    output dmem_ready
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/bubble/flush/freeze sequencing for the 5-stage ARM pipeline,
//            data-memory wait/timeout FSM and saturating stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32,
  parameter int XZR     = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic               id_use1,
  input  logic               id_use2,
  input  logic               id_flag_use,
  input  logic               id_br_taken,
  input  logic [4:0]         ex_rd,
  input  logic               ex_regwrite,
  input  logic               ex_memread,
  input  logic               ex_flagup,
  input  logic               mem_access,
  pipe_hazard_ctrl_if.master dmem,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_flush,
  output logic               idex_bubble,
  output logic               pipe_en,
  output logic               bus_err,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  localparam int         WCW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] c_wait_last = WCW'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [WCW-1:0]   r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;
  logic w_flag_haz;
  logic w_hazard;
  logic w_freeze;
  logic w_stall_inc;

  // ---------------------------------------------------------------------------
  // Hazard detection. ALU results are forwarded, so only loads and flags stall.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rs1_hit  = id_use1 && (id_rs1 == ex_rd);
    w_rs2_hit  = id_use2 && (id_rs2 == ex_rd);
    w_load_use = ex_memread && ex_regwrite && (ex_rd != 5'(XZR))
                 && (w_rs1_hit || w_rs2_hit);
    w_flag_haz = id_flag_use && ex_flagup;
    w_hazard   = w_load_use || w_flag_haz;
  end

  always_comb begin
    w_freeze = 1'b0;
    case (r_state)
      ST_RUN:  w_freeze = mem_access && !dmem.dmem_ready;
      ST_WAIT: w_freeze = !dmem.dmem_ready;
      ST_ERR:  w_freeze = 1'b1;
      default: w_freeze = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Enables, priority freeze > hazard > branch. A branch resolved under a
  // hazard uses stale operands, so it is not allowed to flush.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_en     = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
    end else if (w_freeze) begin
      pc_en       = 1'b0;
    end else if (w_hazard) begin
      pipe_en     = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      pipe_en     = 1'b1;
      ifid_flush  = id_br_taken;
    end
  end

  // The MEM stage is held during a freeze, so the request stays stable.
  assign dmem.dmem_req = mem_access && (r_state != ST_ERR) && !reset;
  assign bus_err       = (r_state == ST_ERR) && !reset;
  assign state         = r_state;
  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;

  assign w_stall_inc   = (w_freeze || w_hazard) && (r_state != ST_ERR);

  // ---------------------------------------------------------------------------
  // Data-memory wait FSM. wait_cnt counts not-ready cycles including the
  // first one seen in RUN, so ERR follows exactly TIMEOUT of them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (mem_access && !dmem.dmem_ready) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= WCW'(1);
          end
        end
        ST_WAIT: begin
          if (dmem.dmem_ready) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == c_wait_last) begin
            r_state    <= ST_ERR;
          end else begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
          end
        end
        ST_ERR: begin
          r_state <= ST_ERR;
        end
        default: begin
          r_state    <= ST_ERR;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (ifid_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed bench for pipe_hazard_ctrl (default build and CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use1, id_use2, id_flag_use, id_br_taken;
  logic       ex_regwrite, ex_memread, ex_flagup;
  logic       mem_access, dmem_ready;

  logic        pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en, bus_err;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt;

  logic        pc_en4, ifid_en4, ifid_flush4, idex_bubble4, pipe_en4, bus_err4;
  logic [1:0]  state4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl_if dif ();
  pipe_hazard_ctrl_if dif4 ();
  assign dif.dmem_ready  = dmem_ready;
  assign dif4.dmem_ready = dmem_ready;

  pipe_hazard_ctrl #(.TIMEOUT(16), .CNT_W(32), .XZR(31)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .id_flag_use(id_flag_use), .id_br_taken(id_br_taken),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_flagup(ex_flagup), .mem_access(mem_access), .dmem(dif),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_en(pipe_en), .bus_err(bus_err),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.TIMEOUT(16), .CNT_W(4), .XZR(31)) dut4 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .id_flag_use(id_flag_use), .id_br_taken(id_br_taken),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_flagup(ex_flagup), .mem_access(mem_access), .dmem(dif4),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4),
    .idex_bubble(idex_bubble4), .pipe_en(pipe_en4), .bus_err(bus_err4),
    .state(state4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use1 = 1'b0; id_use2 = 1'b0; id_flag_use = 1'b0; id_br_taken = 1'b0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_flagup = 1'b0;
    mem_access = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic load_use_in(input logic [4:0] rd);
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = rd;
    id_use1 = 1'b1; id_rs1 = rd;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    // ---- reset state ----
    chk("rst_pc_en",   32'(pc_en),   32'd0);
    chk("rst_pipe_en", 32'(pipe_en), 32'd0);
    chk("rst_state",   32'(state),   32'd0);
    chk("rst_stall",   stall_cnt,    32'd0);
    reset = 1'b0;
    #1;
    chk("run_pc_en",   32'(pc_en),   32'd1);

    // ---- load-use on rs1 ----
    load_use_in(5'd1);
    #1;
    chk("lu_pc_en",  32'(pc_en),       32'd0);
    chk("lu_ifid",   32'(ifid_en),     32'd0);
    chk("lu_bubble", 32'(idex_bubble), 32'd1);
    chk("lu_pipe",   32'(pipe_en),     32'd1);
    tick();
    ex_memread = 1'b0;
    #1;
    chk("lu_after_pc", 32'(pc_en), 32'd1);
    chk("lu_stall1",   stall_cnt,  32'd1);

    // ---- XZR never hazards ----
    load_use_in(5'd31);
    #1;
    chk("xzr_pc_en",  32'(pc_en),       32'd1);
    chk("xzr_bubble", 32'(idex_bubble), 32'd0);
    tick();
    chk("xzr_stall",  stall_cnt, 32'd1);

    // ---- load-use on rs2, and non-reading / non-writing cases ----
    idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7;
    id_rs2 = 5'd7; id_use2 = 1'b1;
    #1;
    chk("lu2_bubble", 32'(idex_bubble), 32'd1);
    id_use2 = 1'b0;
    #1;
    chk("nouse_pc_en", 32'(pc_en), 32'd1);
    id_use2 = 1'b1; ex_regwrite = 1'b0;
    #1;
    chk("norw_pc_en", 32'(pc_en), 32'd1);

    // ---- flag hazard with taken B.LT ----
    idle();
    do_reset();
    ex_flagup = 1'b1; id_flag_use = 1'b1; id_br_taken = 1'b1;
    #1;
    chk("fh_pc_en",  32'(pc_en),      32'd0);
    chk("fh_flush",  32'(ifid_flush), 32'd0);
    chk("fh_bubble", 32'(idex_bubble),32'd1);
    tick();
    ex_flagup = 1'b0;
    #1;
    chk("fh1_flush", 32'(ifid_flush), 32'd1);
    chk("fh1_pc_en", 32'(pc_en),      32'd1);
    tick();
    idle();
    #1;
    chk("fh_flush_cnt", flush_cnt, 32'd1);
    chk("fh_stall_cnt", stall_cnt, 32'd1);

    // ---- memory wait: 3 not-ready cycles then ready ----
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0;
    #1;
    chk("mw0_pipe",  32'(pipe_en), 32'd0);
    chk("mw0_state", 32'(state),   32'd0);
    chk("mw0_req",   32'(dif.dmem_req), 32'd1);
    tick();
    chk("mw1_pipe",  32'(pipe_en), 32'd0);
    chk("mw1_state", 32'(state),   32'd1);
    tick();
    chk("mw2_pipe",  32'(pipe_en), 32'd0);
    chk("mw2_state", 32'(state),   32'd1);
    tick();
    dmem_ready = 1'b1;
    #1;
    chk("mw3_pipe",  32'(pipe_en), 32'd1);
    chk("mw3_state", 32'(state),   32'd1);
    tick();
    idle();
    #1;
    chk("mw_state_run", 32'(state), 32'd0);
    chk("mw_stall",     stall_cnt,  32'd3);

    // ---- freeze beats hazard ----
    mem_access = 1'b1; dmem_ready = 1'b0;
    load_use_in(5'd4);
    #1;
    chk("fz_bubble", 32'(idex_bubble), 32'd0);
    chk("fz_pipe",   32'(pipe_en),     32'd0);
    idle();

    // ---- timeout into ERR ----
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
    end
    chk("to_state",   32'(state),        32'd2);
    chk("to_bus_err", 32'(bus_err),      32'd1);
    chk("to_req",     32'(dif.dmem_req), 32'd0);
    chk("to_pipe",    32'(pipe_en),      32'd0);
    chk("to_stall",   stall_cnt,         32'd16);
    dmem_ready = 1'b1;
    tick();
    tick();
    chk("to_sticky",  32'(bus_err),      32'd1);
    chk("to_stall_hold", stall_cnt,      32'd16);
    reset = 1'b1;
    #1;
    chk("rerr_bus_err", 32'(bus_err),      32'd0);
    chk("rerr_req",     32'(dif.dmem_req), 32'd0);
    chk("rerr_pc_en",   32'(pc_en),        32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rerr_state", 32'(state), 32'd0);
    chk("rerr_stall", stall_cnt,  32'd0);
    chk("rerr_flush", flush_cnt,  32'd0);

    // ---- saturation in the 4-bit build ----
    idle();
    do_reset();
    load_use_in(5'd2);
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    chk("sat_cnt4",  32'(stall_cnt4), 32'd15);
    chk("sat_cnt32", stall_cnt,       32'd20);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage ARM CPU. It sits beside the ID-stage decoder and generates the stall, bubble, flush and freeze enables for the PC and the pipeline registers. It covers load-use hazards, flag hazards for B.LT, and taken-branch squash. It also runs the data-memory wait/timeout state machine and keeps saturating stall and flush counters.

## Interface
Parameters:
- TIMEOUT, 16, max consecutive not-ready data-memory cycles before error (>=2)
- CNT_W, 32, width of performance counters
- XZR, 31, zero register index; never causes a hazard

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_rs1  in  5  first source register of ID instruction (Rn)
- id_rs2  in  5  second source register after Reg2Loc mux (Rm or Rd)
- id_use1, id_use2  in  1  ID instruction actually reads id_rs1 / id_rs2
- id_flag_use  in  1  ID instruction reads flags (B.LT)
- id_br_taken  in  1  branch resolved taken in ID (B, B.LT, CBZ)
- ex_rd  in  5  destination register of EX instruction
- ex_regwrite, ex_memread, ex_flagup  in  1  EX-stage RegWrite / MemRead / FlagUp
- mem_access  in  1  MEM stage holds LDUR or STUR
- dmem_ready  in  1  data memory completes the access this cycle
- dmem_req  out  1  data memory request
- pc_en, ifid_en  out  1  PC / IF-ID register enables
- ifid_flush  out  1  clear IF-ID to NOP
- idex_bubble  out  1  load NOP into ID-EX instead of the ID instruction
- pipe_en  out  1  enable for ID-EX, EX-MEM, MEM-WB registers
- bus_err  out  1  sticky data-memory timeout error
- state  out  2  FSM state: RUN=0, WAIT=1, ERR=2
- stall_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation
- load_use = ex_memread & ex_regwrite & ex_rd!=XZR & ((id_use1 & id_rs1==ex_rd) | (id_use2 & id_rs2==ex_rd)).
- flag_haz = id_flag_use & ex_flagup. Flags are written at the end of EX, so B.LT waits one cycle.
- hazard = load_use | flag_haz. ALU-result hazards are handled by the forwarding unit and are not stalled here.
- freeze = (state==RUN & mem_access & !dmem_ready) | (state==WAIT & !dmem_ready) | state==ERR.
- Output priority (freeze > hazard > branch):
  - freeze: pc_en=0, ifid_en=0, pipe_en=0, idex_bubble=0, ifid_flush=0.
  - else hazard: pc_en=0, ifid_en=0, pipe_en=1, idex_bubble=1, ifid_flush=0. id_br_taken is ignored because its operands are stale.
  - else: pc_en=1, ifid_en=1, pipe_en=1, idex_bubble=0, ifid_flush=id_br_taken.
- dmem_req = mem_access & state!=ERR. The request holds stable during a freeze because the MEM stage is held.
- FSM:
  - RUN: mem_access & !dmem_ready -> WAIT with wait_cnt=1; otherwise stay in RUN.
  - WAIT: dmem_ready -> RUN and wait_cnt=0. Else, if wait_cnt==TIMEOUT-1 -> ERR; else wait_cnt+1.
  - ERR: stays until reset. bus_err = (state==ERR).
- stall_cnt increments in any cycle with (freeze | hazard) & state!=ERR.
- flush_cnt increments when ifid_flush=1.
- Both counters saturate at all-ones and never wrap.

## Timing
- All enables and flushes are combinational from the current inputs and state, with zero latency. They act at the next clock edge.
- The state, wait_cnt and counters are registered.
- A load-use stall lasts exactly one cycle: after the bubble, the load has moved to MEM and load_use drops.
- A flag stall lasts one cycle.
- A data-memory wait of N not-ready cycles followed by a ready cycle freezes for exactly N cycles.
- ERR is entered after exactly TIMEOUT consecutive not-ready cycles (counting the first RUN cycle). bus_err is visible from the following cycle.
- Simultaneous hazard and freeze: freeze wins and the hazard is re-evaluated once unfrozen.
- Simultaneous hazard and id_br_taken: no flush; the branch is re-resolved next cycle.
- During reset high:
  - outputs: all enables=0, flush/bubble=0, dmem_req=0, bus_err=0.
  - next state: state<=RUN, wait_cnt<=0, counters<=0.
  - Reset mid-WAIT or mid-ERR returns to RUN on the next edge.

## Test plan
- Load-use: ex_memread=1, ex_regwrite=1, ex_rd=1, id_use1=1, id_rs1=1. Required: pc_en=0, ifid_en=0, idex_bubble=1 for one cycle; stall_cnt 0->1.
- Same as above with ex_rd=id_rs1=31 -> no stall, pc_en=1, stall_cnt unchanged.
- Flag hazard:
  - Cycle 0: ex_flagup=1, id_flag_use=1, id_br_taken=1. Required: stall, ifid_flush=0.
  - Cycle 1: ex_flagup=0, id_br_taken=1. Required: ifid_flush=1, flush_cnt=1.
- Memory wait:
  - Stimulus: mem_access=1, dmem_ready=0 for 3 cycles, then 1.
  - Required: pipe_en=0 for 3 cycles and 1 on the 4th; state RUN->WAIT->WAIT->RUN; stall_cnt=3.
- Timeout with TIMEOUT=16 and dmem_ready held 0. Required: state=ERR after 16 cycles, bus_err=1 sticky, dmem_req=0, pipe_en=0, stall_cnt stops at 16. One reset cycle -> RUN, bus_err=0, counters=0.
- Saturation: preload stall_cnt to all-ones via a CNT_W=4 build and run 20 stall cycles. Required: stall_cnt stays at 15.
